hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard detection and pipeline-control unit for the 5-stage MIPS pipeline, sitting directly upstream of the control-signal bubble muxes between ID and ID/EX.
- Detects load-use hazards and taken-branch flushes, and drives the mux select that zeroes ID control signals. Select 1 picks the zero input, i.e. a bubble.
- Also drives PC write-enable, IF/ID write-enable and IF/ID flush, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_W, 5, register-specifier width.
- LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard. Legal range 1..4.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  ID source register rs.
- id_rt  in  REG_W  ID source register rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_memread  in  1  ID instruction is a load.
- id_regwrite  in  1  ID instruction writes a register.
- id_dest  in  REG_W  ID destination register (post RegDst selection).
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- ctrl_sel  out  1  bubble select for the control muxes (1 = zero controls).
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- States: RUN, STALL. Internal state also holds ex_ld_valid, ex_ld_rd[REG_W], and rem (remaining-stall counter, 2 bits).
- Outputs are combinational from the current state and inputs. All internal state updates on the rising clk edge.
- While rst=1: ctrl_sel=1, ifid_flush=1, pc_write=0, ifid_write=0. On the edge: state=RUN, ex_ld_valid=0, ex_ld_rd=0, rem=0, stall_cnt=0. Reset mid-stall aborts the stall, with no residual bubble after release.
- hazard = id_valid & ex_ld_valid & (ex_ld_rd != 0) & ((id_uses_rs & id_rs == ex_ld_rd) | (id_uses_rt & id_rt == ex_ld_rd)). Register $0 never causes a hazard.
- Priority: rst > ex_branch_taken > STALL state > hazard > normal.
- ex_branch_taken (any state): ctrl_sel=1, ifid_flush=1, pc_write=1, ifid_write=1. Next state is RUN, rem=0, ex_ld_valid=0. Any pending stall is aborted and stall_cnt does not increment.
- RUN with hazard: ctrl_sel=1, pc_write=0, ifid_write=0, ifid_flush=0, and stall_cnt increments.
  - If LOAD_USE_STALL=1, state stays RUN.
  - Otherwise state goes to STALL with rem=LOAD_USE_STALL-2.
- STALL: same outputs as a hazard cycle, and stall_cnt increments. If rem==0, go to RUN; else rem decrements. The hazard is not re-evaluated in STALL.
- RUN without hazard: ctrl_sel=0, pc_write=1, ifid_write=1, ifid_flush=0.
- EX-load tracking, updated every edge:
  - If ctrl_sel=1 this cycle (bubble enters EX): ex_ld_valid<=0.
  - Else: ex_ld_valid<=id_valid & id_memread & id_regwrite, and ex_ld_rd<=id_dest.
- Total bubbles per hazard = LOAD_USE_STALL exactly. The dependent instruction leaves ID on the edge after the last bubble cycle.
- stall_cnt saturates at all-ones and does not wrap.
- Back-to-back loads: a load that enters EX after a stall is itself tracked normally.

Test Plan:
- Load-use on rs: cycle0 ID=lw $5 (memread, regwrite, dest=5), valid. Cycle1 ID=add reading rs=5 (uses_rs=1). -> Cycle1: ctrl_sel=1, pc_write=0, ifid_write=0. Cycle2: ctrl_sel=0, pc_write=1. stall_cnt=1.
- No false stall: lw dest=0 followed by a reader of $0 -> no stall. lw dest=7 followed by an instruction with rt=7 and uses_rt=0 -> no stall. stall_cnt stays 0.
- LOAD_USE_STALL=3 with a load-use on rt=9 -> exactly 3 consecutive cycles of ctrl_sel=1 / pc_write=0, state sequence RUN,STALL,STALL,RUN, stall_cnt=3.
- Branch flush: ex_branch_taken=1 for one cycle with no hazard -> ctrl_sel=1, ifid_flush=1, pc_write=1, ifid_write=1 that cycle only, and ex_ld_valid=0 next cycle.
- Branch during STALL (LOAD_USE_STALL=3, branch raised in the 2nd bubble cycle) -> flush outputs that cycle, state RUN next cycle, no further bubbles, stall_cnt=1.
- rst asserted for 1 cycle mid-STALL -> outputs ctrl_sel=1, ifid_flush=1, pc_write=0 during reset; after release ctrl_sel=0, pc_write=1 and stall_cnt=0. Separately, force 2^CNT_W+5 stall cycles -> stall_cnt holds all-ones.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Load-use / taken-branch hazard unit for the 5-stage MIPS pipeline.
// Drives the ID control bubble select, PC/IF-ID enables, IF-ID flush and a stall counter.
module hazard_ctrl #(
    parameter int REG_W          = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_memread,
    input  logic             id_regwrite,
    input  logic [REG_W-1:0] id_dest,
    input  logic             ex_branch_taken,
    output logic             ctrl_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    // The hazard cycle itself is the first bubble, so STALL covers the remaining LOAD_USE_STALL-1.
    localparam logic [1:0] REM_INIT = (LOAD_USE_STALL > 1) ? 2'(LOAD_USE_STALL - 2) : 2'd0;

    logic [0:0]       state;
    logic [1:0]       rem;
    logic             ex_ld_valid;
    logic [REG_W-1:0] ex_ld_rd;
    logic             rs_match;
    logic             rt_match;
    logic             hazard;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign rs_match = id_uses_rs & (id_rs == ex_ld_rd);
    assign rt_match = id_uses_rt & (id_rt == ex_ld_rd);
    assign hazard   = id_valid & ex_ld_valid & (ex_ld_rd != '0) & (rs_match | rt_match);

    always_comb begin
        ctrl_sel   = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        if (rst) begin
            ctrl_sel   = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl_sel   = 1'b1;
            ifid_flush = 1'b1;
        end else if ((state == STALL) || hazard) begin
            ctrl_sel   = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            rem         <= 2'd0;
            ex_ld_valid <= 1'b0;
            ex_ld_rd    <= '0;
            stall_cnt   <= '0;
        end else if (ex_branch_taken) begin
            state       <= RUN;
            rem         <= 2'd0;
            ex_ld_valid <= 1'b0;
        end else if (state == STALL) begin
            stall_cnt   <= sat_inc(stall_cnt);
            ex_ld_valid <= 1'b0;
            if (rem == 2'd0) begin
                state <= RUN;
            end else begin
                rem <= rem - 2'd1;
            end
        end else if (hazard) begin
            stall_cnt   <= sat_inc(stall_cnt);
            ex_ld_valid <= 1'b0;
            if (LOAD_USE_STALL > 1) begin
                state <= STALL;
                rem   <= REM_INIT;
            end
        end else begin
            // No bubble this cycle: the ID instruction moves into EX.
            ex_ld_valid <= id_valid & id_memread & id_regwrite;
            ex_ld_rd    <= id_dest;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one instance with a single-bubble stall and 16-bit
// counter, one with a 3-bubble stall and a 4-bit counter, driven by the same ID stream.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_memread;
    logic       id_regwrite;
    logic [4:0] id_dest;
    logic       ex_branch_taken;

    logic        ctrl_sel1, pc_write1, ifid_write1, ifid_flush1;
    logic [15:0] cnt1;
    logic        ctrl_sel3, pc_write3, ifid_write3, ifid_flush3;
    logic [3:0]  cnt3;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] o1;
        logic [3:0] o3;
        int         c1;
        int         c3;
    } exp_t;

    exp_t sb[$];

    // Reference model state, index 0 = single-bubble DUT, 1 = three-bubble DUT.
    logic       m_ldv[2];
    logic [4:0] m_ldrd[2];
    int         m_left[2];
    int         m_cnt[2];

    hazard_ctrl #(.REG_W(5), .LOAD_USE_STALL(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_memread(id_memread),
        .id_regwrite(id_regwrite), .id_dest(id_dest), .ex_branch_taken(ex_branch_taken),
        .ctrl_sel(ctrl_sel1), .pc_write(pc_write1), .ifid_write(ifid_write1),
        .ifid_flush(ifid_flush1), .stall_cnt(cnt1)
    );

    hazard_ctrl #(.REG_W(5), .LOAD_USE_STALL(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_memread(id_memread),
        .id_regwrite(id_regwrite), .id_dest(id_dest), .ex_branch_taken(ex_branch_taken),
        .ctrl_sel(ctrl_sel3), .pc_write(pc_write3), .ifid_write(ifid_write3),
        .ifid_flush(ifid_flush3), .stall_cnt(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs packed as {ctrl_sel, pc_write, ifid_write, ifid_flush}.
    task automatic model_eval(input int k, input int lus, input int cmax,
                              output logic [3:0] o, output int c);
        logic reads;
        logic haz;
        c     = m_cnt[k];
        reads = (id_uses_rs && id_rs == m_ldrd[k]) || (id_uses_rt && id_rt == m_ldrd[k]);
        haz   = id_valid && m_ldv[k] && (m_ldrd[k] != 5'd0) && reads;
        if (rst) begin
            o         = 4'b1001;
            m_ldv[k]  = 1'b0;
            m_ldrd[k] = 5'd0;
            m_left[k] = 0;
            m_cnt[k]  = 0;
        end else if (ex_branch_taken) begin
            o         = 4'b1111;
            m_ldv[k]  = 1'b0;
            m_left[k] = 0;
        end else if (m_left[k] > 0 || haz) begin
            o         = 4'b1000;
            m_left[k] = (m_left[k] > 0) ? m_left[k] - 1 : lus - 1;
            m_ldv[k]  = 1'b0;
            if (m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
        end else begin
            o         = 4'b0110;
            m_ldv[k]  = id_valid && id_memread && id_regwrite;
            m_ldrd[k] = id_dest;
        end
    endtask

    task automatic drive(input string tag, input logic r, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic mr, input logic rw,
                         input logic [4:0] dest, input logic br);
        exp_t e;
        @(negedge clk);
        rst             = r;
        id_valid        = v;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rs      = urs;
        id_uses_rt      = urt;
        id_memread      = mr;
        id_regwrite     = rw;
        id_dest         = dest;
        ex_branch_taken = br;
        e.tag = tag;
        model_eval(0, 1, 65535, e.o1, e.c1);
        model_eval(1, 3, 15, e.o3, e.c3);
        sb.push_back(e);
    endtask

    task automatic reset_cycle();
        drive("rst", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive("idle", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] dest);
        drive("lw", 1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, dest, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_out1"}, {ctrl_sel1, pc_write1, ifid_write1, ifid_flush1}, e.o1);
            check({e.tag, "_out3"}, {ctrl_sel3, pc_write3, ifid_write3, ifid_flush3}, e.o3);
            if (e.c1 >= 0) check({e.tag, "_cnt1"}, cnt1, e.c1);
            if (e.c3 >= 0) check({e.tag, "_cnt3"}, cnt3, e.c3);
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ldv[k]  = 1'b0;
            m_ldrd[k] = 5'd0;
            m_left[k] = 0;
            m_cnt[k]  = -1;
        end
        rst = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_memread = 1'b0;
        id_regwrite = 1'b0; id_dest = 5'd0; ex_branch_taken = 1'b0;

        reset_cycle();
        reset_cycle();

        // Load-use on rs: lw $5, then add reading $5 held in ID while stalled.
        lw(5'd5);
        for (int i = 0; i < 4; i++)
            drive("use_rs", 1'b0, 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
        idle(2);
        #3;
        check("lu_rs_cnt1", cnt1, 1);
        check("lu_rs_cnt3", cnt3, 3);

        // No false stalls: load to $0, and an unread matching rt.
        reset_cycle();
        lw(5'd0);
        drive("rd0", 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
        lw(5'd7);
        drive("rt7_unused", 1'b0, 1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
        idle(1);
        #3;
        check("nofalse_cnt1", cnt1, 0);
        check("nofalse_cnt3", cnt3, 0);

        // Load-use on rt=9 with state sequence on the three-bubble instance.
        reset_cycle();
        lw(5'd9);
        drive("use_rt", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        #3 check("rt_state_c1", u_dut3.state, 0);
        drive("use_rt", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        #3 check("rt_state_c2", u_dut3.state, 1);
        drive("use_rt", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        #3 check("rt_state_c3", u_dut3.state, 1);
        drive("use_rt", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        #3 check("rt_state_c4", u_dut3.state, 0);
        idle(1);
        #3 check("lu_rt_cnt3", cnt3, 3);

        // Branch flush with a would-be hazard in ID; load tracking is cleared.
        reset_cycle();
        lw(5'd4);
        drive("br", 1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 1'b1);
        drive("after_br", 1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0);
        #3;
        check("br_ldv1", u_dut1.ex_ld_valid, 0);
        check("br_cnt1", cnt1, 0);

        // Branch in the second bubble cycle aborts the stall.
        reset_cycle();
        lw(5'd9);
        drive("st_haz", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        drive("st_br", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1);
        drive("st_post", 1'b0, 1'b0, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        #3;
        check("st_br_state3", u_dut3.state, 0);
        check("st_br_cnt3", cnt3, 1);
        idle(2);

        // Reset in the middle of a stall leaves no residual bubble.
        reset_cycle();
        lw(5'd9);
        drive("rs_haz", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        drive("rs_st", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        drive("rs_mid", 1'b1, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        drive("rs_rel", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        #3;
        check("rs_ctrl3", ctrl_sel3, 0);
        check("rs_cnt3", cnt3, 0);

        // 21 = 2^4+5 stall cycles on the 4-bit counter.
        reset_cycle();
        for (int i = 0; i < 7; i++) begin
            lw(5'd9);
            for (int j = 0; j < 4; j++)
                drive("sat", 1'b0, 1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b0);
        end
        idle(1);
        #3;
        check("sat_cnt3", cnt3, 15);
        check("sat_cnt1", cnt1, 7);

        @(negedge clk);
        #5;
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
